// File: rtl/ff_pkg.sv
// Shared types and next-state logic for the ff_bank flip-flop primitive.
// ff_next is the single definition of per-bit JK / D / T / SR behaviour.
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    // True when an SR cell sees S=R=1; that bit holds and the error flag is raised.
    function automatic logic sr_illegal(input mode_e mode, input logic a, input logic b);
        return (mode == MODE_SR) && a && b;
    endfunction

    function automatic logic ff_next(input mode_e mode, input logic a,
                                     input logic b, input logic q);
        logic nxt;
        nxt = q;
        case (mode)
            MODE_JK: begin
                case ({a, b})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            MODE_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ff_cell.sv
// One storage bit: registered q, one-cycle change pulse and a combinational
// SR-illegal indication for the bank-level sticky error.
module ff_cell
    import ff_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  a,
    input  logic  b,
    output logic  q,
    output logic  changed,
    output logic  illegal
);

    logic next_q;

    always_comb begin
        next_q = q;
        if (en) begin
            next_q = ff_next(mode, a, b, q);
        end
    end

    assign illegal = sr_illegal(mode, a, b);

    // changed is computed from the same next_q, so the pulse lands with the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RESET_BIT;
            changed <= 1'b0;
        end else begin
            q       <= next_q;
            changed <= next_q ^ q;
        end
    end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flops sharing clock, enable and mode,
// with per-bit change pulses and a sticky SR-illegal error flag.
module ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err
);

    mode_e            mode_sel;
    logic [WIDTH-1:0] illegal;
    logic             err_set;

    assign mode_sel = mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .mode    (mode_sel),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .changed (changed[i]),
            .illegal (illegal[i])
        );
    end

    assign q_bar   = ~q;
    assign err_set = en && (|illegal);

    // Set has priority so an error on the clearing edge is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_err <= 1'b0;
        end else if (err_set) begin
            sr_err <= 1'b1;
        end else if (err_clr) begin
            sr_err <= 1'b0;
        end
    end

endmodule
